// File: rtl/pipe_hazard_ctrl.sv
// Issue gate between IDU and EXU: RAW/WAW scoreboard, in-flight limit,
// serialising instructions and the one-cycle branch-verdict/flush sequence.
module pipe_hazard_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic [4:0]  id_rd,
    input  logic        id_regwrite,
    input  logic        id_is_ctrl,
    input  logic        id_serial,
    input  logic        ex_ready,
    input  logic        ex_control_hazard,
    input  logic [31:0] ex_pc_next,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        wb_regwrite,
    output logic        ex_valid,
    output logic        id_ready,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic [2:0]  inflight,
    output logic [31:0] busy_mask,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SHADOW = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    state_t      state_q, state_d;
    logic [31:0] busy_mask_q, busy_mask_d;
    logic [2:0]  inflight_q, inflight_d;
    logic        serial_pend_q, serial_pend_d;
    logic        err_q, err_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic        raw_s, waw_s, blocked_s, fire_s, wb_eff_s;
    logic [31:0] set_mask_s, clr_mask_s;

    // Issue gating; the scoreboard is read from the register only, so a
    // retire in this cycle cannot release a dependent issue until next cycle.
    always_comb begin
        raw_s = (id_rs1_used && (id_rs1 != 5'd0) && busy_mask_q[id_rs1]) ||
                (id_rs2_used && (id_rs2 != 5'd0) && busy_mask_q[id_rs2]);
        waw_s = id_regwrite && (id_rd != 5'd0) && busy_mask_q[id_rd];
        blocked_s = raw_s || waw_s ||
                    (inflight_q == DEPTH_C) ||
                    (state_q != ST_RUN) ||
                    serial_pend_q ||
                    (id_serial && (inflight_q != 3'd0));
        fire_s   = id_valid && !blocked_s && ex_ready;
        ex_valid = id_valid && !blocked_s;
        id_ready = ex_ready && !blocked_s;
    end

    // Scoreboard, in-flight counter, serialisation and error bookkeeping.
    always_comb begin
        clr_mask_s  = (wb_valid && wb_regwrite && (wb_rd != 5'd0)) ? (32'd1 << wb_rd) : 32'd0;
        set_mask_s  = (fire_s && id_regwrite && (id_rd != 5'd0)) ? (32'd1 << id_rd) : 32'd0;
        busy_mask_d = (busy_mask_q & ~clr_mask_s) | set_mask_s;

        // A retire with nothing in flight is spurious: counted as an error only.
        wb_eff_s = wb_valid && (inflight_q != 3'd0);
        case ({fire_s, wb_eff_s})
            2'b10:   inflight_d = inflight_q + 3'd1;
            2'b01:   inflight_d = inflight_q - 3'd1;
            default: inflight_d = inflight_q;
        endcase
        err_d = err_q || (wb_valid && (inflight_q == 3'd0));

        if (fire_s && id_serial) begin
            serial_pend_d = 1'b1;
        end else if (inflight_q == 3'd0) begin
            serial_pend_d = 1'b0;
        end else begin
            serial_pend_d = serial_pend_q;
        end
    end

    // Control-transfer sequencer: RUN -> SHADOW (verdict) -> optional FLUSH.
    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        case (state_q)
            ST_RUN: begin
                if (fire_s && id_is_ctrl) begin
                    state_d = ST_SHADOW;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_SHADOW: begin
                if (ex_control_hazard) begin
                    state_d       = ST_FLUSH;
                    redirect_pc_d = ex_pc_next;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RUN;
            busy_mask_q   <= 32'd0;
            inflight_q    <= 3'd0;
            serial_pend_q <= 1'b0;
            err_q         <= 1'b0;
            redirect_pc_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            busy_mask_q   <= busy_mask_d;
            inflight_q    <= inflight_d;
            serial_pend_q <= serial_pend_d;
            err_q         <= err_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign redirect_valid = (state_q == ST_FLUSH);
    assign flush          = (state_q == ST_FLUSH);
    assign redirect_pc    = redirect_pc_q;
    assign inflight       = inflight_q;
    assign busy_mask      = busy_mask_q;
    assign err            = err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hazards, branch flush, depth limit,
// serialisation, spurious retire and reset during flush.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_rs1_used, id_rs2_used, id_regwrite, id_is_ctrl, id_serial;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
    logic        ex_ready, ex_control_hazard, wb_valid, wb_regwrite;
    logic [31:0] ex_pc_next;
    logic        ex_valid, id_ready, redirect_valid, flush, err;
    logic [31:0] redirect_pc, busy_mask;
    logic [2:0]  inflight;

    int n_checks = 0;
    int n_errors = 0;

    pipe_hazard_ctrl #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_is_ctrl(id_is_ctrl), .id_serial(id_serial),
        .ex_ready(ex_ready), .ex_control_hazard(ex_control_hazard), .ex_pc_next(ex_pc_next),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .ex_valid(ex_valid), .id_ready(id_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush(flush), .inflight(inflight), .busy_mask(busy_mask), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        id_rd = 5'd0; id_regwrite = 1'b0; id_is_ctrl = 1'b0; id_serial = 1'b0;
        ex_ready = 1'b1; ex_control_hazard = 1'b0; ex_pc_next = 32'd0;
        wb_valid = 1'b0; wb_rd = 5'd0; wb_regwrite = 1'b0;
    endtask

    task automatic present(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                           input logic u2, input logic [4:0] rd, input logic rw,
                           input logic ctrl, input logic ser);
        id_valid = 1'b1; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
        id_rd = rd; id_regwrite = rw; id_is_ctrl = ctrl; id_serial = ser;
    endtask

    task automatic retire(input logic [4:0] rd, input logic rw);
        wb_valid = 1'b1; wb_rd = rd; wb_regwrite = rw;
    endtask

    task automatic no_retire();
        wb_valid = 1'b0; wb_rd = 5'd0; wb_regwrite = 1'b0;
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        id_valid = 1'b1;
        #2;
        check_eq("rst_inflight", 32'(inflight), 32'd0);
        check_eq("rst_busy", busy_mask, 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_rpc", redirect_pc, 32'd0);
        check_eq("rst_flush", 32'(flush), 32'd0);
        check_eq("rst_redir", 32'(redirect_valid), 32'd0);
        check_eq("rst_ex_valid", 32'(ex_valid), 32'd1);
        check_eq("rst_id_ready", 32'(id_ready), 32'd1);
        tick();
        rst = 1'b0;
        idle();
        tick();

        // RAW: add x5 then sub x6,x5,x1 stalls until the cycle after x5 retires.
        present(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        #1 check_eq("add_ex_valid", 32'(ex_valid), 32'd1);
        tick();
        present(5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        #1;
        check_eq("raw_busy5", busy_mask, 32'h0000_0020);
        check_eq("raw_stall", 32'(id_ready), 32'd0);
        check_eq("raw_exv", 32'(ex_valid), 32'd0);
        tick();
        retire(5'd5, 1'b1);
        #1 check_eq("raw_no_bypass", 32'(id_ready), 32'd0);
        tick();
        no_retire();
        #1;
        check_eq("raw_busy_clr", busy_mask, 32'd0);
        check_eq("raw_released", 32'(id_ready), 32'd1);
        tick();
        idle();
        retire(5'd6, 1'b1);
        #1 check_eq("sub_busy6", busy_mask, 32'h0000_0040);
        tick();
        no_retire();
        #1 check_eq("a_drained", 32'(inflight), 32'd0);

        // Branch with mispredict: flush one cycle, next issue 3 cycles after beq.
        present(5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
        tick();
        present(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        ex_control_hazard = 1'b1; ex_pc_next = 32'h8000_0040;
        #1;
        check_eq("shadow_block", 32'(id_ready), 32'd0);
        check_eq("shadow_redir", 32'(redirect_valid), 32'd0);
        check_eq("shadow_flush", 32'(flush), 32'd0);
        tick();
        ex_control_hazard = 1'b0; ex_pc_next = 32'd0;
        #1;
        check_eq("flush_redir", 32'(redirect_valid), 32'd1);
        check_eq("flush_flush", 32'(flush), 32'd1);
        check_eq("flush_rpc", redirect_pc, 32'h8000_0040);
        check_eq("flush_no_issue", 32'(ex_valid), 32'd0);
        check_eq("flush_keeps_inflight", 32'(inflight), 32'd1);
        tick();
        #1;
        check_eq("post_flush_issue", 32'(ex_valid), 32'd1);
        check_eq("post_flush_redir", 32'(redirect_valid), 32'd0);
        tick();
        idle();
        retire(5'd0, 1'b0);
        tick();
        retire(5'd7, 1'b1);
        tick();
        no_retire();
        #1 check_eq("b_drained", 32'(inflight), 32'd0);

        // Ctrl without mispredict: issue resumes 2 cycles later; stray hazard ignored.
        present(5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0);
        tick();
        present(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        #1 check_eq("jal_shadow_block", 32'(id_ready), 32'd0);
        tick();
        ex_control_hazard = 1'b1;
        #1 check_eq("jal_resume", 32'(ex_valid), 32'd1);
        tick();
        idle();
        #1 check_eq("stray_hazard_flush", 32'(flush), 32'd0);
        retire(5'd1, 1'b1);
        tick();
        retire(5'd8, 1'b1);
        tick();
        no_retire();

        // Depth limit and concurrent issue/retire.
        for (int i = 0; i < 4; i++) begin
            present(5'd0, 1'b0, 5'd0, 1'b0, 5'(10 + i), 1'b1, 1'b0, 1'b0);
            #1 check_eq("fill_issue", 32'(ex_valid), 32'd1);
            tick();
        end
        present(5'd0, 1'b0, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0);
        #1;
        check_eq("full_inflight", 32'(inflight), 32'd4);
        check_eq("full_block", 32'(ex_valid), 32'd0);
        retire(5'd10, 1'b1);
        #1 check_eq("full_still_block", 32'(id_ready), 32'd0);
        tick();
        retire(5'd11, 1'b1);
        #1 check_eq("both_fire", 32'(ex_valid), 32'd1);
        tick();
        idle();
        #1;
        check_eq("both_inflight", 32'(inflight), 32'd3);
        check_eq("both_busy", busy_mask, 32'h0000_7000);
        for (int i = 0; i < 3; i++) begin
            retire(5'(12 + i), 1'b1);
            tick();
        end
        no_retire();
        #1 check_eq("c_drained", 32'(inflight), 32'd0);

        // Serialising csrrw waits for an empty pipe and then holds off younger.
        for (int i = 0; i < 2; i++) begin
            present(5'd0, 1'b0, 5'd0, 1'b0, 5'(15 + i), 1'b1, 1'b0, 1'b0);
            tick();
        end
        present(5'd1, 1'b1, 5'd0, 1'b0, 5'd17, 1'b1, 1'b0, 1'b1);
        #1 check_eq("csr_wait2", 32'(id_ready), 32'd0);
        retire(5'd15, 1'b1);
        tick();
        #1 check_eq("csr_wait1", 32'(id_ready), 32'd0);
        retire(5'd16, 1'b1);
        tick();
        no_retire();
        #1 check_eq("csr_issue", 32'(ex_valid), 32'd1);
        tick();
        present(5'd0, 1'b0, 5'd0, 1'b0, 5'd18, 1'b1, 1'b0, 1'b0);
        #1 check_eq("csr_young_block", 32'(id_ready), 32'd0);
        tick();
        #1 check_eq("csr_young_block2", 32'(ex_valid), 32'd0);
        retire(5'd17, 1'b1);
        tick();
        idle();
        tick();
        present(5'd0, 1'b0, 5'd0, 1'b0, 5'd18, 1'b1, 1'b0, 1'b0);
        #1 check_eq("csr_young_go", 32'(ex_valid), 32'd1);
        tick();
        idle();
        retire(5'd18, 1'b1);
        tick();
        no_retire();

        // x0 writes never mark the scoreboard and x0 reads never stall.
        present(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        present(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        check_eq("x0_busy", busy_mask, 32'd0);
        check_eq("x0_no_stall", 32'(id_ready), 32'd1);
        tick();
        idle();
        retire(5'd0, 1'b1);
        tick();
        tick();
        no_retire();
        #1 check_eq("e_drained", 32'(inflight), 32'd0);

        // Spurious retire sets sticky err; reset in FLUSH clears everything at once.
        retire(5'd3, 1'b1);
        tick();
        no_retire();
        #1;
        check_eq("spurious_err", 32'(err), 32'd1);
        check_eq("spurious_inflight", 32'(inflight), 32'd0);
        present(5'd0, 1'b0, 5'd0, 1'b0, 5'd20, 1'b1, 1'b1, 1'b0);
        tick();
        idle();
        ex_control_hazard = 1'b1; ex_pc_next = 32'h0000_1234;
        tick();
        ex_control_hazard = 1'b0;
        #1 check_eq("pre_rst_flush", 32'(flush), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_flush", 32'(flush), 32'd0);
        check_eq("rst_mid_redir", 32'(redirect_valid), 32'd0);
        check_eq("rst_mid_rpc", redirect_pc, 32'd0);
        check_eq("rst_mid_busy", busy_mask, 32'd0);
        check_eq("rst_mid_inflight", 32'(inflight), 32'd0);
        check_eq("rst_mid_err", 32'(err), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check_eq("post_rst_redir1", 32'(redirect_valid), 32'd0);
        tick();
        check_eq("post_rst_redir2", 32'(redirect_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
